// File: rtl/inst_buffer_pkg.sv
// Shared constants for the decode-to-rename instruction buffer.
// The decoded packet width is built from the individual decode field widths.
package inst_buffer_pkg;

    localparam int SPEC_REG_W  = 2;
    localparam int LDST_TYPE_W = 3;
    localparam int INST_TYPE_W = 4;
    localparam int IMM_W       = 32;
    localparam int RMT_W       = 32;
    localparam int OPCODE_W    = 7;
    localparam int PC_W        = 32;
    localparam int CTI_W       = 16;

    localparam int PKT_W = SPEC_REG_W + LDST_TYPE_W + INST_TYPE_W + IMM_W
                         + RMT_W + OPCODE_W + PC_W + CTI_W;

    localparam int WIDTH         = 4;
    localparam int DEPTH_DEFAULT = 32;

endpackage

// File: rtl/inst_buffer_ram.sv
// DEPTH x PKT_W storage with one aligned WIDTH-wide write port and WIDTH
// asynchronous read ports starting at a group-aligned read index.
module inst_buffer_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        i_wr_en,
    input  logic [PTR_W-1:0]            i_wr_idx,
    input  logic [WIDTH-1:0][PKT_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]            i_rd_idx,
    output logic [WIDTH-1:0][PKT_W-1:0] o_rd_data
);

    logic [PKT_W-1:0] r_mem [DEPTH];

    // Indices are always group-aligned, so idx+n never wraps inside a group.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int n = 0; n < WIDTH; n++) begin
                r_mem[i_wr_idx + PTR_W'(n)] <= i_wr_data[n];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < WIDTH; n++) begin
            o_rd_data[n] = r_mem[i_rd_idx + PTR_W'(n)];
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Elastic group FIFO between Decode and the Decode/Rename latch.
// Define INST_BUFFER_PERF_EN to add full/stall saturating cycle counters.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             decode_ready_i,
    input  logic [PKT_W-1:0] decoded_packet0_i,
    input  logic [PKT_W-1:0] decoded_packet1_i,
    input  logic [PKT_W-1:0] decoded_packet2_i,
    input  logic [PKT_W-1:0] decoded_packet3_i,
    output logic             buf_full_o,
    output logic             buf_ready_o,
    output logic [PKT_W-1:0] decoded_packet0_o,
    output logic [PKT_W-1:0] decoded_packet1_o,
    output logic [PKT_W-1:0] decoded_packet2_o,
    output logic [PKT_W-1:0] decoded_packet3_o,
    output logic [CNT_W-1:0] occupancy_o
`ifdef INST_BUFFER_PERF_EN
    ,
    output logic [31:0]      full_cycles_o,
    output logic [31:0]      stall_cycles_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] GRP_STEP  = PTR_W'(WIDTH);
    localparam logic [CNT_W-1:0] GRP_CNT   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic                        w_wr;
    logic                        w_rd;
    logic                        w_clear;
    logic [WIDTH-1:0][PKT_W-1:0] w_wr_data;
    logic [WIDTH-1:0][PKT_W-1:0] w_rd_data;

    // Handshake: decode_ready_i is a valid that transfers when buf_full_o=0,
    // otherwise the producer holds the same group; buf_ready_o is a valid
    // toward Rename that transfers when stall_i=0, and the head group stays
    // stable while stalled. Both flags depend on registered count only.
    assign buf_full_o  = (DEPTH_CNT - r_count) < GRP_CNT;
    assign buf_ready_o = r_count >= GRP_CNT;
    assign w_wr        = decode_ready_i & ~buf_full_o;
    assign w_rd        = buf_ready_o & ~stall_i;
    assign w_clear     = reset | flush_i;
    assign occupancy_o = r_count;

    assign w_wr_data = {decoded_packet3_i, decoded_packet2_i,
                        decoded_packet1_i, decoded_packet0_i};

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_tail <= r_tail + GRP_STEP;
            if (w_rd) r_head <= r_head + GRP_STEP;
            r_count <= r_count + (w_wr ? GRP_CNT : '0) - (w_rd ? GRP_CNT : '0);
        end
    end

    inst_buffer_ram #(.DEPTH(DEPTH)) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr & ~w_clear),
        .i_wr_idx  (r_tail),
        .i_wr_data (w_wr_data),
        .i_rd_idx  (r_head),
        .o_rd_data (w_rd_data)
    );

    assign decoded_packet0_o = w_rd_data[0];
    assign decoded_packet1_o = w_rd_data[1];
    assign decoded_packet2_o = w_rd_data[2];
    assign decoded_packet3_o = w_rd_data[3];

`ifdef INST_BUFFER_PERF_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_stall_cycles;

    // Flush deliberately leaves these alone; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full_cycles  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (buf_full_o && decode_ready_i && (r_full_cycles != '1))
                r_full_cycles <= r_full_cycles + 32'd1;
            if (buf_ready_o && stall_i && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign full_cycles_o  = r_full_cycles;
    assign stall_cycles_o = r_stall_cycles;
`endif

    a_count_le_depth: assert property (@(posedge clk) disable iff (reset)
        r_count <= DEPTH_CNT);
    a_count_aligned: assert property (@(posedge clk) disable iff (reset)
        (r_count % GRP_CNT) == '0);
    a_ptr_count: assert property (@(posedge clk) disable iff (reset)
        (r_tail - r_head) == r_count[PTR_W-1:0]);
    a_upstream_hold: assert property (@(posedge clk) disable iff (reset)
        (decode_ready_i && buf_full_o && !flush_i) |=>
        (decode_ready_i && $stable(decoded_packet0_i) && $stable(decoded_packet1_i)
         && $stable(decoded_packet2_i) && $stable(decoded_packet3_i)));

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: queue-based reference model, per-cycle
// compare process, directed scenarios plus a randomized phase.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic reset;
    logic flush_i;
    logic stall_i;
    logic decode_ready_i;
    logic [PKT_W-1:0] pkt_i [4];
    logic [PKT_W-1:0] pkt_o [4];
    logic buf_full_o;
    logic buf_ready_o;
    logic [CNT_W-1:0] occupancy_o;
`ifdef INST_BUFFER_PERF_EN
    logic [31:0] full_cycles_o;
    logic [31:0] stall_cycles_o;
`endif

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (flush_i),
        .stall_i           (stall_i),
        .decode_ready_i    (decode_ready_i),
        .decoded_packet0_i (pkt_i[0]),
        .decoded_packet1_i (pkt_i[1]),
        .decoded_packet2_i (pkt_i[2]),
        .decoded_packet3_i (pkt_i[3]),
        .buf_full_o        (buf_full_o),
        .buf_ready_o       (buf_ready_o),
        .decoded_packet0_o (pkt_o[0]),
        .decoded_packet1_o (pkt_o[1]),
        .decoded_packet2_o (pkt_o[2]),
        .decoded_packet3_o (pkt_o[3]),
        .occupancy_o       (occupancy_o)
`ifdef INST_BUFFER_PERF_EN
        ,
        .full_cycles_o     (full_cycles_o),
        .stall_cycles_o    (stall_cycles_o)
`endif
    );

    // ---------------- scoreboard / model state ----------------
    logic [PKT_W-1:0] exp_q[$];
    bit acc_last;
    bit chk_en;
    bit hold;
    int n_checks;
    int n_pass;
    int unsigned m_full_cyc;
    int unsigned m_stall_cyc;

    task automatic chk(input string name, input logic [PKT_W-1:0] act,
                       input logic [PKT_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the buffer is a queue of instructions moved in groups of WIDTH.
    int sz;
    bit m_full;
    bit m_ready;
    bit m_wr;
    bit m_rd;
    always @(posedge clk) begin
        sz      = exp_q.size();
        m_full  = (DEPTH - sz) < WIDTH;
        m_ready = sz >= WIDTH;
        m_wr    = decode_ready_i && !m_full;
        m_rd    = m_ready && !stall_i;
        if (reset) begin
            m_full_cyc  = 0;
            m_stall_cyc = 0;
        end else begin
            if (m_full && decode_ready_i) m_full_cyc++;
            if (m_ready && stall_i) m_stall_cyc++;
        end
        if (reset || flush_i) begin
            exp_q.delete();
            acc_last = 1'b0;
        end else begin
            if (m_rd) repeat (WIDTH) void'(exp_q.pop_front());
            if (m_wr) for (int n = 0; n < WIDTH; n++) exp_q.push_back(pkt_i[n]);
            acc_last = m_wr;
        end
    end

    // Compare process, away from the active edge.
    int c_sz;
    always @(negedge clk) begin
        if (chk_en) begin
            c_sz = exp_q.size();
            chk("occupancy", PKT_W'(occupancy_o), PKT_W'(c_sz));
            chk("buf_full", PKT_W'(buf_full_o), PKT_W'((DEPTH - c_sz) < WIDTH));
            chk("buf_ready", PKT_W'(buf_ready_o), PKT_W'(c_sz >= WIDTH));
            if (c_sz >= WIDTH) begin
                for (int n = 0; n < WIDTH; n++) chk($sformatf("pkt%0d", n), pkt_o[n], exp_q[n]);
            end
`ifdef INST_BUFFER_PERF_EN
            chk("full_cycles", PKT_W'(full_cycles_o), PKT_W'(m_full_cyc));
            chk("stall_cycles", PKT_W'(stall_cycles_o), PKT_W'(m_stall_cyc));
`endif
        end
    end

    // ---------------- driver ----------------
    // One clock: apply inputs, let the edge consume them, return at edge+1.
    // A rejected group is held with the same payload until accepted.
    task automatic cycle(input logic dr, input logic st, input logic fl,
                         input logic rs, input logic gen);
        if (hold) dr = 1'b1;
        if (dr && !hold && gen) begin
            for (int n = 0; n < WIDTH; n++)
                pkt_i[n] = {$urandom, $urandom, $urandom, $urandom};
        end
        decode_ready_i = dr;
        stall_i        = st;
        flush_i        = fl;
        reset          = rs;
        @(posedge clk);
        #1;
        hold = dr && !acc_last && !fl && !rs;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_occ"}, PKT_W'(occupancy_o), '0);
        chk({tag, "_ready"}, PKT_W'(buf_ready_o), '0);
        chk({tag, "_full"}, PKT_W'(buf_full_o), '0);
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; stall_i = 1'b0; decode_ready_i = 1'b0;
        for (int n = 0; n < 4; n++) pkt_i[n] = '0;
        hold = 1'b0; chk_en = 1'b0; n_checks = 0; n_pass = 0;

        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk_en = 1'b1;
        chk_idle("reset");

        // Single group, single-cycle latency
        pkt_i[0] = 128'hA0; pkt_i[1] = 128'hA1; pkt_i[2] = 128'hA2; pkt_i[3] = 128'hA3;
        cycle(1, 0, 0, 0, 0);
        chk("lat_ready", PKT_W'(buf_ready_o), PKT_W'(1));
        chk("lat_occ", PKT_W'(occupancy_o), PKT_W'(4));
        chk("lat_a0", pkt_o[0], 128'hA0);
        chk("lat_a1", pkt_o[1], 128'hA1);
        chk("lat_a2", pkt_o[2], 128'hA2);
        chk("lat_a3", pkt_o[3], 128'hA3);
        cycle(0, 0, 0, 0, 0);
        chk_idle("drain1");

        // Fill under stall, reject the 9th group, then drain in order
        repeat (8) cycle(1, 1, 0, 0, 1);
        chk("fill_occ", PKT_W'(occupancy_o), PKT_W'(32));
        chk("fill_full", PKT_W'(buf_full_o), PKT_W'(1));
        cycle(1, 1, 0, 0, 1);
        chk("reject_occ", PKT_W'(occupancy_o), PKT_W'(32));
        cycle(1, 0, 0, 0, 1);
        chk("free_occ", PKT_W'(occupancy_o), PKT_W'(28));
        repeat (10) cycle(0, 0, 0, 0, 1);
        chk_idle("drain2");

        // Streaming steady state across several wraps
        cycle(1, 0, 0, 0, 1);
        repeat (20) begin
            cycle(1, 0, 0, 0, 1);
            chk("steady_occ", PKT_W'(occupancy_o), PKT_W'(4));
        end
        cycle(0, 0, 0, 0, 1);

        // Flush with a simultaneous incoming group
        repeat (3) cycle(1, 1, 0, 0, 1);
        chk("pre_flush_occ", PKT_W'(occupancy_o), PKT_W'(12));
        cycle(1, 0, 1, 0, 1);
        chk_idle("flush");
        cycle(0, 0, 0, 0, 1);
        chk_idle("post_flush");

        // Reset mid-stream at occupancy 16, then a fresh group
        repeat (4) cycle(1, 1, 0, 0, 1);
        chk("pre_rst_occ", PKT_W'(occupancy_o), PKT_W'(16));
        cycle(0, 1, 0, 1, 1);
        chk_idle("mid_reset");
        pkt_i[0] = 128'hB0; pkt_i[1] = 128'hB1; pkt_i[2] = 128'hB2; pkt_i[3] = 128'hB3;
        cycle(1, 0, 0, 0, 0);
        chk("fresh_ready", PKT_W'(buf_ready_o), PKT_W'(1));
        chk("fresh_b0", pkt_o[0], 128'hB0);
        chk("fresh_b3", pkt_o[3], 128'hB3);
        cycle(0, 0, 0, 0, 0);

        // Randomized traffic: stall-heavy, then drain-heavy
        for (int i = 0; i < 400; i++) begin
            if (i < 200)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 40) == 0, 1'b0, 1'b1);
            else
                cycle($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 40) == 0, 1'b0, 1'b1);
        end
        repeat (10) cycle(0, 0, 0, 0, 1);
        chk_idle("final_drain");

`ifdef INST_BUFFER_PERF_EN
        cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1);
        repeat (5) cycle(0, 1, 0, 0, 1);
        chk("perf_stall5", PKT_W'(stall_cycles_o), PKT_W'(5));
        cycle(0, 0, 1, 0, 1);
        chk("perf_stall_flush", PKT_W'(stall_cycles_o), PKT_W'(5));
        chk("perf_full0", PKT_W'(full_cycles_o), PKT_W'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
